// File: rtl/logic_gate_pipe.sv
// Bitwise gate unit with a 2-entry result FIFO and valid/ready handshakes.
// Head entry, its parity and in_ready are all registered outputs.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_par,
    output logic [CNT_W-1:0] done_cnt
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d, occ_p;
    logic             in_ready_q, in_ready_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [WIDTH-1:0] res;
    logic             push, pop;

    always_comb begin
        res = '0;
        unique case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: res = ~(a & b);
            3'd3: res = ~(a | b);
            3'd4: res = a ^ b;
            3'd5: res = ~(a ^ b);
            3'd6: res = ~a;
            3'd7: res = a;
            default: res = '0;
        endcase
    end

    // Shift-register FIFO: ent0 is always the head, so y needs no mux.
    always_comb begin
        push   = in_valid & in_ready_q;
        pop    = (occ_q != 2'd0) & out_ready;
        occ_p  = occ_q - {1'b0, pop};
        ent0_d = pop ? ent1_q : ent0_q;
        ent1_d = ent1_q;
        if (push) begin
            if (occ_p == 2'd0) ent0_d = res;
            else               ent1_d = res;
        end
        occ_d      = occ_p + {1'b0, push};
        in_ready_d = (occ_d < 2'd2);
        par_d      = ^ent0_d;
        done_cnt_d = pop ? done_cnt_q + CNT_W'(1) : done_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b0;
            par_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            par_q      <= par_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != 2'd0);
    assign y         = ent0_q;
    assign y_par     = par_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_logic_gate_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_par;
    logic [CNT_W-1:0] done_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;

    logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_par(y_par), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are stable around the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt = '0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got y=%0h expected none", y);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                chk("y", y, e);
                chk("y_par", y_par, ^e);
                chk("done_cnt_run", done_cnt, exp_cnt);
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] e);
        int n;
        @(posedge clk); #2;
        op = o; a = av; b = bv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else begin
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #2;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y_par", y_par, 0);
        chk("rst_done_cnt", done_cnt, 0);
        exp_q.delete();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
    endtask

    initial begin
        int t0;
        logic [7:0] i8;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        #1;
        chk("init_in_ready", in_ready, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_done_cnt", done_cnt, 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init_rel_in_ready", in_ready, 1);

        // Sweep all ops.
        out_ready = 1'b1;
        send(3'd0, 8'hF0, 8'hCC, 8'hC0);
        send(3'd1, 8'hF0, 8'hCC, 8'hFC);
        send(3'd2, 8'hF0, 8'hCC, 8'h3F);
        send(3'd3, 8'hF0, 8'hCC, 8'h03);
        send(3'd4, 8'hF0, 8'hCC, 8'h3C);
        send(3'd5, 8'hF0, 8'hCC, 8'hC3);
        send(3'd6, 8'hF0, 8'hCC, 8'h0F);
        send(3'd7, 8'hF0, 8'hCC, 8'hF0);
        idle();
        drain();
        chk("sweep_done_cnt", done_cnt, 8);

        // Latency into empty buffer.
        out_ready = 1'b0;
        send(3'd2, 8'h01, 8'h01, 8'hFE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_y", y, 8'hFE);
        chk("lat_y_par", y_par, 1);
        out_ready = 1'b1;
        drain();

        // Backpressure.
        pulse_reset();
        out_ready = 1'b0;
        send(3'd0, 8'hFF, 8'h0F, 8'h0F);
        send(3'd1, 8'h30, 8'h03, 8'h33);
        @(posedge clk); #1;
        chk("bp_in_ready_full", in_ready, 0);
        op = 3'd5; a = 8'hAA; b = 8'h55;
        @(posedge clk); #1;
        chk("bp_in_ready_hold", in_ready, 0);
        chk("bp_head_stable", y, 8'h0F);
        #1;
        out_ready = 1'b1;
        send(3'd5, 8'hAA, 8'h55, 8'h00);
        idle();
        drain();
        chk("bp_done_cnt", done_cnt, 3);

        // Streaming push+pop at occupancy 1.
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            i8 = 8'(i);
            send(3'd4, i8, 8'h55, i8 ^ 8'h55);
        end
        idle();
        chk("stream_cycles", cyc - t0, 11);
        chk("stream_out_valid", out_valid, 1);
        drain();

        // Reset with two entries buffered.
        out_ready = 1'b0;
        send(3'd4, 8'hA5, 8'h0F, 8'hAA);
        send(3'd7, 8'h12, 8'h00, 8'h12);
        idle();
        chk("mid_out_valid_pre", out_valid, 1);
        pulse_reset();
        out_ready = 1'b1;
        send(3'd3, 8'h00, 8'h00, 8'hFF);
        idle();
        drain();
        chk("mid_done_cnt", done_cnt, 1);

        // Counter wrap.
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            i8 = 8'(i);
            send(3'd6, i8, 8'h00, ~i8);
        end
        idle();
        drain();
        chk("wrap_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result bit width, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the completed-transaction counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 op  input  3  gate select, sampled with the beat.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand; ignored for op 6 and op 7.
REQ-010 out_valid  output  1  result available at the buffer head.
REQ-011 out_ready  input  1  consumer accepts the head result.
REQ-012 y  output  WIDTH  bitwise result at the buffer head.
REQ-013 y_par  output  1  XOR-reduction (parity) of y.
REQ-014 done_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-015 Op encoding, per bit: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
REQ-016 An input beat is accepted on a rising edge where in_valid and in_ready are both 1; a, b and op are sampled only at that edge.
REQ-017 The result of an accepted beat is written into a 2-entry FIFO output buffer at the accepting edge.
REQ-018 Latency: when the buffer is empty, out_valid rises in the cycle after acceptance, with y equal to the result.
REQ-019 Results leave the buffer in acceptance order, with no loss and no duplication.
REQ-020 out_valid = 1 exactly when buffer occupancy is non-zero.
REQ-021 y and y_par always reflect the head entry, come from registers, and hold stable while out_valid is 1 and out_ready is 0.
REQ-022 An output handshake occurs on a rising edge where out_valid and out_ready are both 1; it pops the head entry.
REQ-023 in_ready is a registered output equal to 1 when post-edge occupancy is below 2.
REQ-024 With occupancy 1, a simultaneous push and pop keeps occupancy at 1, and the new result becomes head next cycle.
REQ-025 With occupancy 2, in_ready is 0, so no push occurs; a pop that edge reduces occupancy to 1 and sets in_ready to 1 next cycle.
REQ-026 A pop with occupancy 0 cannot occur, because out_valid is 0.
REQ-027 in_valid asserted while in_ready is 0 has no effect; the source must hold the beat.
REQ-028 done_cnt increments by 1 on each output handshake and wraps from all-ones to 0 without a flag.
REQ-029 y_par equals the XOR of all WIDTH bits of y, for every WIDTH.

Reset
REQ-030 While rst_n is 0: in_ready = 0, out_valid = 0, y = 0, y_par = 0, done_cnt = 0, and occupancy = 0, all applied immediately and independent of clk.
REQ-031 Reset asserted mid-operation discards all buffered results; no handshake completes while rst_n is 0.
REQ-032 in_ready goes to 1 at the first rising edge after rst_n deasserts.

Verification
REQ-033 Sweep, WIDTH=8, a=8'hF0, b=8'hCC, ops 0..7, out_ready=1 -> y = C0, FC, 3F, 03, 3C, C3, 0F, F0; y_par = 0, 0, 0, 0, 0, 0, 0, 0; done_cnt = 8.
REQ-034 Latency: single beat op=2, a=8'h01, b=8'h01 into an empty block -> out_valid high the next cycle, y=8'hFE, y_par=1.
REQ-035 Backpressure: out_ready=0, three back-to-back beats -> first two accepted, in_ready=0 from the cycle after the second; raise out_ready -> both results emerge in order, third beat then accepted, done_cnt=3.
REQ-036 Simultaneous push and pop at occupancy 1 over 10 cycles with in_valid=out_ready=1 -> one result per cycle, in order, occupancy constant at 1.
REQ-037 Reset mid-stream with 2 entries buffered -> out_valid, y, done_cnt go to 0 asynchronously; in_ready returns to 1 one edge after release; no stale result appears.
REQ-038 Wrap: CNT_W=4, 17 handshakes -> done_cnt reads 1.
